// File: rtl/vending_buyer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vending_buyer_if
//  Description : Request-side and machine-side signal bundle of the vending
//                buyer. The slave modport is the buyer itself; the master
//                modport is whatever drives requests and models the machine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vending_buyer_if;
  // request side
  logic       req_valid;
  logic [1:0] req_item;
  logic [1:0] req_c50;
  logic [1:0] req_c10;
  logic [1:0] req_c5;
  logic [1:0] req_c1;
  logic       req_ready;

  // machine side
  logic [1:0] vm_service;
  logic [1:0] vm_item;
  logic [2:0] vm_out50;
  logic [2:0] vm_out10;
  logic [2:0] vm_out5;
  logic [2:0] vm_out1;
  logic [1:0] coin_in50;
  logic [1:0] coin_in10;
  logic [1:0] coin_in5;
  logic [1:0] coin_in1;
  logic [1:0] item_in;

  // status / result
  logic       done;
  logic       reject;
  logic       timeout;
  logic [1:0] got_item;
  logic [8:0] change;
  logic       p;

  modport slave (
    input  req_valid, req_item, req_c50, req_c10, req_c5, req_c1,
    input  vm_service, vm_item, vm_out50, vm_out10, vm_out5, vm_out1,
    output req_ready,
    output coin_in50, coin_in10, coin_in5, coin_in1, item_in,
    output done, reject, timeout, got_item, change, p
  );

  modport master (
    output req_valid, req_item, req_c50, req_c10, req_c5, req_c1,
    output vm_service, vm_item, vm_out50, vm_out10, vm_out5, vm_out1,
    input  req_ready,
    input  coin_in50, coin_in10, coin_in5, coin_in1, item_in,
    input  done, reject, timeout, got_item, change, p
  );
endinterface
`default_nettype wire

// File: rtl/vending_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : vending_buyer
//  Description : Buyer side of a vending-machine handshake. Holds a small
//                coin wallet, checks each purchase request against it, waits
//                for the machine to come on, presents coins and item for one
//                cycle, waits for the machine to go off, captures the item and
//                change, flags a wrong outcome and settles the wallet.
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_buyer (
  input wire             clk,
  input wire             reset,
  vending_buyer_if.slave bus
);

  // FSM encoding
  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WAIT_ON  = 3'd1;
  localparam logic [2:0] c_ISSUE    = 3'd2;
  localparam logic [2:0] c_WAIT_OFF = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  // machine service codes and item codes
  localparam logic [1:0] c_SVC_OFF   = 2'b00;
  localparam logic [1:0] c_SVC_ON    = 2'b01;
  localparam logic [1:0] c_ITEM_NONE = 2'b00;
  localparam logic [1:0] c_ITEM_A    = 2'b01;
  localparam logic [1:0] c_ITEM_B    = 2'b10;
  localparam logic [1:0] c_ITEM_C    = 2'b11;

  // item prices
  localparam logic [7:0] c_COST_A = 8'd8;
  localparam logic [7:0] c_COST_B = 8'd15;
  localparam logic [7:0] c_COST_C = 8'd22;

  // wallet start value and ceiling
  localparam logic [3:0] c_WALLET_INIT = 4'd3;
  localparam logic [4:0] c_WALLET_MAX  = 5'd15;

  // watchdog: expires as it steps from 62 to 63
  localparam logic [5:0] c_WD_LAST = 6'd62;
  localparam logic [5:0] c_WD_MAX  = 6'd63;

  logic [2:0] r_state;
  logic [5:0] r_wd;

  // wallet
  logic [3:0] r_w50;
  logic [3:0] r_w10;
  logic [3:0] r_w5;
  logic [3:0] r_w1;

  // latched request
  logic [1:0] r_c50;
  logic [1:0] r_c10;
  logic [1:0] r_c5;
  logic [1:0] r_c1;
  logic [1:0] r_item;

  // captured change coins, kept for the wallet update in DONE
  logic [2:0] r_o50;
  logic [2:0] r_o10;
  logic [2:0] r_o5;
  logic [2:0] r_o1;

  logic [1:0] r_got_item;
  logic [8:0] r_change;
  logic       r_reject;
  logic       r_timeout;

  logic       w_req_bad;
  logic       w_in_issue;
  logic [7:0] w_paid;
  logic [7:0] w_cost;
  logic [8:0] w_vm_change;
  logic       w_p;

  // new wallet count: w - c + o, clamped at 15 (w >= c was checked at request)
  function automatic logic [3:0] f_settle(input logic [3:0] w, input logic [1:0] c,
                                          input logic [2:0] o);
    logic [4:0] s;
    s = {1'b0, w} - {3'b000, c} + {2'b00, o};
    f_settle = (s > c_WALLET_MAX) ? 4'd15 : s[3:0];
  endfunction

  // a request is unserviceable if it names no item or spends coins we lack
  assign w_req_bad = (bus.req_item == c_ITEM_NONE)      ||
                     ({2'b00, bus.req_c50} > r_w50)     ||
                     ({2'b00, bus.req_c10} > r_w10)     ||
                     ({2'b00, bus.req_c5}  > r_w5)      ||
                     ({2'b00, bus.req_c1}  > r_w1);

  // value of the latched coins (at most 198, fits 8 bits)
  assign w_paid = ({6'd0, r_c50} * 8'd50) + ({6'd0, r_c10} * 8'd10) +
                  ({6'd0, r_c5}  * 8'd5)  +  {6'd0, r_c1};

  // value of the machine's change coins (at most 462, needs all 9 bits)
  assign w_vm_change = ({6'd0, bus.vm_out50} * 9'd50) + ({6'd0, bus.vm_out10} * 9'd10) +
                       ({6'd0, bus.vm_out5}  * 9'd5)  +  {6'd0, bus.vm_out1};

  // price of the latched item
  always_comb begin
    w_cost = 8'd0;
    case (r_item)
      c_ITEM_A: w_cost = c_COST_A;
      c_ITEM_B: w_cost = c_COST_B;
      c_ITEM_C: w_cost = c_COST_C;
      default:  w_cost = 8'd0;
    endcase
  end

  // outcome check: a refund must return everything, a sale must deliver the
  // requested item with exact change for a price we could afford
  always_comb begin
    w_p = 1'b0;
    if (r_state == c_DONE) begin
      if (r_got_item == c_ITEM_NONE) begin
        w_p = (r_change != {1'b0, w_paid});
      end else begin
        w_p = (r_got_item != r_item) ||
              (w_paid < w_cost)      ||
              (r_change != {1'b0, w_paid - w_cost});
      end
    end
  end

  assign w_in_issue = (r_state == c_ISSUE);

  assign bus.req_ready = (r_state == c_IDLE);
  assign bus.coin_in50 = w_in_issue ? r_c50  : 2'b00;
  assign bus.coin_in10 = w_in_issue ? r_c10  : 2'b00;
  assign bus.coin_in5  = w_in_issue ? r_c5   : 2'b00;
  assign bus.coin_in1  = w_in_issue ? r_c1   : 2'b00;
  assign bus.item_in   = w_in_issue ? r_item : c_ITEM_NONE;
  assign bus.done      = (r_state == c_DONE);
  assign bus.reject    = r_reject;
  assign bus.timeout   = r_timeout;
  assign bus.got_item  = r_got_item;
  assign bus.change    = r_change;
  assign bus.p         = w_p;

  // transaction sequencing, watchdog and the reject/timeout pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_wd      <= 6'd0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.req_valid) begin
            if (w_req_bad) begin
              r_reject <= 1'b1;
            end else begin
              r_wd    <= 6'd0;
              r_state <= c_WAIT_ON;
            end
          end
        end
        c_WAIT_ON: begin
          if (bus.vm_service == c_SVC_ON) begin
            r_state <= c_ISSUE;
          end else if (r_wd == c_WD_LAST) begin
            r_wd      <= c_WD_MAX;
            r_timeout <= 1'b1;
            r_state   <= c_IDLE;
          end else begin
            r_wd <= r_wd + 6'd1;
          end
        end
        c_ISSUE: begin
          // the machine must still be on at the end of the issue cycle,
          // otherwise the coins did not land and we wait to retry
          r_wd    <= 6'd0;
          r_state <= (bus.vm_service == c_SVC_ON) ? c_WAIT_OFF : c_WAIT_ON;
        end
        c_WAIT_OFF: begin
          if (bus.vm_service == c_SVC_OFF) begin
            r_state <= c_DONE;
          end else if (r_wd == c_WD_LAST) begin
            r_wd      <= c_WD_MAX;
            r_timeout <= 1'b1;
            r_state   <= c_IDLE;
          end else begin
            r_wd <= r_wd + 6'd1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // request latch and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_c50      <= 2'b00;
      r_c10      <= 2'b00;
      r_c5       <= 2'b00;
      r_c1       <= 2'b00;
      r_item     <= c_ITEM_NONE;
      r_o50      <= 3'd0;
      r_o10      <= 3'd0;
      r_o5       <= 3'd0;
      r_o1       <= 3'd0;
      r_got_item <= c_ITEM_NONE;
      r_change   <= 9'd0;
    end else begin
      if ((r_state == c_IDLE) && bus.req_valid && !w_req_bad) begin
        r_c50  <= bus.req_c50;
        r_c10  <= bus.req_c10;
        r_c5   <= bus.req_c5;
        r_c1   <= bus.req_c1;
        r_item <= bus.req_item;
      end
      if ((r_state == c_WAIT_OFF) && (bus.vm_service == c_SVC_OFF)) begin
        r_o50      <= bus.vm_out50;
        r_o10      <= bus.vm_out10;
        r_o5       <= bus.vm_out5;
        r_o1       <= bus.vm_out1;
        r_got_item <= bus.vm_item;
        r_change   <= w_vm_change;
      end
    end
  end

  // wallet: settled only on a completed transaction
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w50 <= c_WALLET_INIT;
      r_w10 <= c_WALLET_INIT;
      r_w5  <= c_WALLET_INIT;
      r_w1  <= c_WALLET_INIT;
    end else if (r_state == c_DONE) begin
      r_w50 <= f_settle(r_w50, r_c50, r_o50);
      r_w10 <= f_settle(r_w10, r_c10, r_o10);
      r_w5  <= f_settle(r_w5,  r_c5,  r_o5);
      r_w1  <= f_settle(r_w1,  r_c1,  r_o1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vending_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_buyer
//  Description : Self-checking bench for vending_buyer. Directed purchases,
//                reject, timeout, reset abort and randomized transactions are
//                compared against a wallet/price model kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_buyer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mw[4];   // model wallet: 50, 10, 5, 1

  vending_buyer_if vif();

  vending_buyer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  // observed wallet, packed 50/10/5/1 nibbles
  function automatic logic [15:0] dut_wallet();
    return {dut.r_w50, dut.r_w10, dut.r_w5, dut.r_w1};
  endfunction

  function automatic logic [15:0] model_wallet();
    return {4'(mw[0]), 4'(mw[1]), 4'(mw[2]), 4'(mw[3])};
  endfunction

  function automatic int price(input logic [1:0] item);
    case (item)
      2'b01:   return 8;
      2'b10:   return 15;
      2'b11:   return 22;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] coins_out();
    return {vif.coin_in50, vif.coin_in10, vif.coin_in5, vif.coin_in1};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    vif.req_valid = 1'b0; vif.req_item = 2'b00;
    {vif.req_c50, vif.req_c10, vif.req_c5, vif.req_c1} = 8'h00;
    vif.vm_service = 2'b00; vif.vm_item = 2'b00;
    {vif.vm_out50, vif.vm_out10, vif.vm_out5, vif.vm_out1} = 12'h000;
    repeat (2) @(negedge clk);
    checks++;
    if ({vif.done, vif.reject, vif.timeout, vif.p} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {vif.done, vif.reject, vif.timeout, vif.p});
    end
    checks++;
    if ({vif.got_item, vif.change, vif.item_in, coins_out()} !== 21'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {vif.got_item, vif.change, vif.item_in, coins_out()});
    end
    checks++;
    if (dut_wallet() !== 16'h3333) begin
      errors++; $display("FAIL reset_wallet: got %h want 3333", dut_wallet());
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (vif.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", vif.req_ready);
    end
    for (int i = 0; i < 4; i++) mw[i] = 3;
  endtask

  // one full purchase attempt; c = {c50,c10,c5,c1}, o = {o50,o10,o5,o1}
  task automatic run_txn(input string name, input logic [1:0] item, input logic [7:0] c,
                         input logic [1:0] ret_item, input logic [11:0] o,
                         input int on_dly, input int off_dly, input bit junk);
    int cc[4];
    int oo[4];
    int paid, cost, chg;
    bit exp_rej, exp_p;
    for (int i = 0; i < 4; i++) begin
      cc[i] = int'(c[7-2*i -: 2]);
      oo[i] = int'(o[11-3*i -: 3]);
    end
    paid = 50*cc[0] + 10*cc[1] + 5*cc[2] + cc[3];
    chg  = 50*oo[0] + 10*oo[1] + 5*oo[2] + oo[3];
    cost = price(item);
    exp_rej = (item == 2'b00);
    for (int i = 0; i < 4; i++) if (cc[i] > mw[i]) exp_rej = 1'b1;
    if (ret_item == 2'b00) exp_p = (chg != paid);
    else exp_p = (ret_item != item) || (paid < cost) || (chg != paid - cost);

    @(negedge clk);
    checks++;
    if (vif.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", name, vif.req_ready);
    end
    vif.req_valid = 1'b1; vif.req_item = item;
    {vif.req_c50, vif.req_c10, vif.req_c5, vif.req_c1} = c;
    @(negedge clk);
    vif.req_valid = 1'b0; vif.req_item = 2'b00;
    {vif.req_c50, vif.req_c10, vif.req_c5, vif.req_c1} = 8'h00;
    checks++;
    if (vif.reject !== exp_rej) begin
      errors++; $display("FAIL %s reject: got %b want %b", name, vif.reject, exp_rej);
    end
    if (exp_rej) begin
      checks++;
      if (vif.req_ready !== 1'b1) begin
        errors++; $display("FAIL %s ready_after_reject: got %b want 1", name, vif.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({vif.reject, vif.item_in, coins_out()} !== 11'd0) begin
        errors++; $display("FAIL %s reject_no_issue: got %h want 0", name, {vif.reject, vif.item_in, coins_out()});
      end
      checks++;
      if (dut_wallet() !== model_wallet()) begin
        errors++; $display("FAIL %s wallet_after_reject: got %h want %h", name, dut_wallet(), model_wallet());
      end
      return;
    end

    // waiting for the machine to switch on
    checks++;
    if (vif.req_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_busy: got %b want 0", name, vif.req_ready);
    end
    for (int k = 0; k < on_dly; k++) begin
      vif.vm_service = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if ({vif.item_in, coins_out()} !== 10'd0) begin
        errors++; $display("FAIL %s early_issue: got %h want 0", name, {vif.item_in, coins_out()});
      end
    end
    vif.vm_service = 2'b01;
    @(negedge clk);
    checks++;
    if ({vif.item_in, coins_out()} !== {item, c}) begin
      errors++; $display("FAIL %s issue: got %h want %h", name, {vif.item_in, coins_out()}, {item, c});
    end
    @(negedge clk);
    checks++;
    if ({vif.item_in, coins_out(), vif.done} !== 11'd0) begin
      errors++; $display("FAIL %s after_issue: got %h want 0", name, {vif.item_in, coins_out(), vif.done});
    end

    // machine busy vending; a stray request here must be ignored
    vif.vm_service = 2'b10;
    if (junk) begin
      vif.req_valid = 1'b1; vif.req_item = 2'(($urandom_range(1, 3)));
    end
    for (int k = 0; k < off_dly; k++) begin
      @(negedge clk);
      vif.req_valid = 1'b0; vif.req_item = 2'b00;
      checks++;
      if ({vif.done, vif.reject, vif.timeout, vif.item_in} !== 5'd0) begin
        errors++; $display("FAIL %s vending: got %b want 0", name, {vif.done, vif.reject, vif.timeout, vif.item_in});
      end
    end
    vif.req_valid = 1'b0; vif.req_item = 2'b00;
    vif.vm_service = 2'b00; vif.vm_item = ret_item;
    {vif.vm_out50, vif.vm_out10, vif.vm_out5, vif.vm_out1} = o;
    @(negedge clk);
    checks++;
    if (vif.done !== 1'b1) begin
      errors++; $display("FAIL %s done: got %b want 1", name, vif.done);
    end
    checks++;
    if ({vif.got_item, vif.change} !== {ret_item, 9'(chg)}) begin
      errors++; $display("FAIL %s result: got item %0d change %0d want item %0d change %0d",
                         name, vif.got_item, vif.change, ret_item, chg);
    end
    checks++;
    if (vif.p !== exp_p) begin
      errors++; $display("FAIL %s p: got %b want %b", name, vif.p, exp_p);
    end
    vif.vm_item = 2'b00;
    {vif.vm_out50, vif.vm_out10, vif.vm_out5, vif.vm_out1} = 12'h000;
    for (int i = 0; i < 4; i++) begin
      mw[i] = mw[i] - cc[i] + oo[i];
      if (mw[i] > 15) mw[i] = 15;
    end
    @(negedge clk);
    checks++;
    if ({vif.done, vif.p, vif.req_ready} !== 3'b001) begin
      errors++; $display("FAIL %s after_done: got %b want 001", name, {vif.done, vif.p, vif.req_ready});
    end
    checks++;
    if ({vif.got_item, vif.change} !== {ret_item, 9'(chg)}) begin
      errors++; $display("FAIL %s hold: got %h want %h", name, {vif.got_item, vif.change}, {ret_item, 9'(chg)});
    end
    checks++;
    if (dut_wallet() !== model_wallet()) begin
      errors++; $display("FAIL %s wallet: got %h want %h", name, dut_wallet(), model_wallet());
    end
  endtask

  task automatic test_buy_a();
    run_txn("buy_a", 2'b01, 8'b00_01_00_00, 2'b01, 12'b000_000_000_010, 2, 3, 1'b0);
    checks++;
    if (dut_wallet() !== 16'h3235) begin
      errors++; $display("FAIL buy_a_wallet_abs: got %h want 3235", dut_wallet());
    end
  endtask

  task automatic test_refund_c();
    run_txn("refund_c", 2'b11, 8'b00_01_01_00, 2'b00, 12'b000_001_001_000, 0, 2, 1'b1);
    checks++;
    if (dut_wallet() !== 16'h3235) begin
      errors++; $display("FAIL refund_c_wallet_abs: got %h want 3235", dut_wallet());
    end
  endtask

  task automatic test_bad_change_b();
    run_txn("bad_change_b", 2'b10, 8'b01_00_00_00, 2'b10, 12'b000_011_001_100, 1, 1, 1'b0);
    checks++;
    if (dut_wallet() !== 16'h2549) begin
      errors++; $display("FAIL bad_change_b_wallet_abs: got %h want 2549", dut_wallet());
    end
  endtask

  task automatic test_reject();
    run_txn("reject_c50", 2'b01, 8'b11_00_00_00, 2'b00, 12'h000, 0, 1, 1'b0);
    run_txn("reject_none", 2'b00, 8'b00_00_00_00, 2'b00, 12'h000, 0, 1, 1'b0);
  endtask

  task automatic test_max_change();
    // every return slot full: change 462 and wallet clamps at 15
    run_txn("max_change", 2'b01, 8'h00, 2'b01, 12'hfff, 0, 1, 1'b0);
  endtask

  task automatic test_timeout();
    int  k;
    bit  hit;
    @(negedge clk);
    vif.req_valid = 1'b1; vif.req_item = 2'b01; vif.req_c10 = 2'b01;
    @(negedge clk);
    vif.req_valid = 1'b0; vif.req_item = 2'b00; vif.req_c10 = 2'b00;
    vif.vm_service = 2'b01;
    @(negedge clk);
    checks++;
    if (vif.item_in !== 2'b01) begin
      errors++; $display("FAIL timeout_issue: got %b want 01", vif.item_in);
    end
    @(negedge clk);
    vif.vm_service = 2'b10;
    hit = 1'b0;
    k = 0;
    while (!hit && k < 100) begin
      @(negedge clk);
      k++;
      if (vif.timeout === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit || k != 63) begin
      errors++; $display("FAIL timeout_latency: got %0d (seen %b) want 63", k, hit);
    end
    checks++;
    if ({vif.req_ready, vif.done} !== 2'b10) begin
      errors++; $display("FAIL timeout_idle: got %b want 10", {vif.req_ready, vif.done});
    end
    checks++;
    if (dut_wallet() !== model_wallet()) begin
      errors++; $display("FAIL timeout_wallet: got %h want %h", dut_wallet(), model_wallet());
    end
    @(negedge clk);
    checks++;
    if (vif.timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got %b want 0", vif.timeout);
    end
    vif.vm_service = 2'b00;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    vif.req_valid = 1'b1; vif.req_item = 2'b10; vif.req_c10 = 2'b01; vif.req_c5 = 2'b01;
    @(negedge clk);
    vif.req_valid = 1'b0; vif.req_item = 2'b00; vif.req_c10 = 2'b00; vif.req_c5 = 2'b00;
    vif.vm_service = 2'b01;
    repeat (2) @(negedge clk);
    vif.vm_service = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({vif.req_ready, vif.done, vif.reject, vif.timeout, vif.p} !== 5'b10000) begin
      errors++; $display("FAIL abort_flags: got %b want 10000",
                         {vif.req_ready, vif.done, vif.reject, vif.timeout, vif.p});
    end
    checks++;
    if ({vif.got_item, vif.change, vif.item_in, coins_out()} !== 21'd0) begin
      errors++; $display("FAIL abort_data: got %h want 0", {vif.got_item, vif.change, vif.item_in, coins_out()});
    end
    checks++;
    if (dut_wallet() !== 16'h3333) begin
      errors++; $display("FAIL abort_wallet: got %h want 3333", dut_wallet());
    end
    reset = 1'b1;
    vif.vm_service = 2'b00;
    for (int i = 0; i < 4; i++) mw[i] = 3;
    @(negedge clk);
    checks++;
    if (vif.req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b want 1", vif.req_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]  item, ret;
    logic [7:0]  c;
    logic [11:0] o;
    int cc[4];
    int paid, cost, v, lim, o50, o10, o5, o1;
    for (int t = 0; t < 30; t++) begin
      item = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        lim = ($urandom_range(0, 5) == 0) ? 3 : ((mw[i] < 3) ? mw[i] : 3);
        cc[i] = $urandom_range(0, lim);
      end
      c = {2'(cc[0]), 2'(cc[1]), 2'(cc[2]), 2'(cc[3])};
      paid = 50*cc[0] + 10*cc[1] + 5*cc[2] + cc[3];
      cost = price(item);
      if ($urandom_range(0, 3) == 0) begin
        ret = 2'($urandom_range(0, 3));
        o   = 12'($urandom_range(0, 4095));
      end else begin
        if (paid >= cost) begin ret = item;  v = paid - cost; end
        else              begin ret = 2'b00; v = paid;        end
        o50 = v / 50; v -= 50 * o50;
        o10 = v / 10; v -= 10 * o10;
        o5  = v / 5;  v -= 5 * o5;
        o1  = v;
        o = {3'(o50), 3'(o10), 3'(o5), 3'(o1)};
      end
      run_txn($sformatf("rand%0d", t), item, c, ret, o,
              $urandom_range(0, 20), $urandom_range(1, 30), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_buy_a();
    test_refund_c();
    test_bad_change_b();
    test_reject();
    test_timeout();
    test_max_change();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got time %0t want end of test", $time);
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
